clock_ctrl_fsm: RTL

CLOCK_CTRL_FSM -- requirements
Module: clock_ctrl_fsm

---
 rtl/clock_ctrl_fsm.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/clock_ctrl_fsm.sv
// mm:ss clock with start/stop, set-minutes/set-seconds modes and a synchronous clear.
// Keys are synchronized and debounced; all display and state outputs are registered.
module clock_ctrl_fsm #(
    parameter int TICKS_PER_SEC   = 50000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic [3:0] key_n,
    input  logic [1:0] switches,
    output logic [7:0] leds_minutes_ms,
    output logic [7:0] leds_minutes_ls,
    output logic [6:0] leds_seconds_ms,
    output logic [6:0] leds_seconds_ls,
    output logic [1:0] state
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam int BW = $clog2(TICKS_PER_SEC / 2);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(TICKS_PER_SEC / 2 - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DEB_FULL   = DW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, SET_MIN = 2'b10, SET_SEC = 2'b11} state_t;

    logic [3:0]    key_s1, key_s2;
    logic [1:0]    sw_s1, sw_s2;
    logic [DW-1:0] deb_cnt [4];
    logic [3:0]    press;
    logic          clr_p, start_p, inc_p, dec_p;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    min_q, min_d, sec_q, sec_d;
    logic [BW-1:0] blink_cnt;
    logic          blink_q;
    logic [7:0]    min_ms_d, min_ls_d;
    logic [6:0]    sec_ms_d, sec_ls_d;

    // Two-digit BCD {tens, units} helpers, wrapping within 00..59.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) return (v[7:4] == 4'd0) ? 8'h59 : {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            key_s1 <= 4'hF;
            key_s2 <= 4'hF;
            sw_s1  <= 2'b00;
            sw_s2  <= 2'b00;
        end else begin
            key_s1 <= key_n;
            key_s2 <= key_s1;
            sw_s1  <= switches;
            sw_s2  <= sw_s1;
        end
    end

    // Counter saturates at DEBOUNCE_CYCLES so a held key pulses only once.
    always_ff @(posedge clk_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reset_reset || key_s2[i]) deb_cnt[i] <= '0;
            else if (deb_cnt[i] != DEB_FULL) deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) press[i] = ~key_s2[i] & (deb_cnt[i] == DEB_LAST);
    end

    assign clr_p   = press[3];
    assign start_p = press[0] & ~press[3];
    assign inc_p   = press[1] & ~press[3] & ~press[0];
    assign dec_p   = press[2] & ~press[3] & ~press[0] & ~press[1];

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            min_q     <= '0;
            sec_q     <= '0;
            blink_cnt <= '0;
            blink_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            if (state_d[1] && state_d != state_q) begin
                blink_cnt <= '0;
                blink_q   <= 1'b0;
            end else if (state_q[1]) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blink_q   <= ~blink_q;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end else begin
                blink_cnt <= '0;
                blink_q   <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        min_d   = min_q;
        sec_d   = sec_q;
        case (sw_s2)
            2'b01:   state_d = SET_MIN;
            2'b10:   state_d = SET_SEC;
            default: begin
                if (state_q[1]) state_d = IDLE;
                else if (start_p) state_d = (state_q == IDLE) ? RUN : IDLE;
            end
        endcase
        // Clear outranks every other update, including a coincident tick.
        if (clr_p) begin
            presc_d = '0;
            min_d   = '0;
            sec_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (start_p) presc_d = '0;
                RUN: begin
                    if (!start_p) begin
                        if (presc_q == PRESC_LAST) begin
                            presc_d = '0;
                            if (sec_q == 8'h59) begin
                                sec_d = '0;
                                min_d = bcd_inc(min_q);
                            end else begin
                                sec_d = bcd_inc(sec_q);
                            end
                        end else begin
                            presc_d = presc_q + PW'(1);
                        end
                    end
                end
                SET_MIN: begin
                    if (inc_p) min_d = bcd_inc(min_q);
                    else if (dec_p) min_d = bcd_dec(min_q);
                end
                SET_SEC: begin
                    if (inc_p) sec_d = bcd_inc(sec_q);
                    else if (dec_p) sec_d = bcd_dec(sec_q);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        min_ms_d = {1'b1, seg7(min_q[7:4])};
        min_ls_d = {(state_q != RUN), seg7(min_q[3:0])};
        sec_ms_d = seg7(sec_q[7:4]);
        sec_ls_d = seg7(sec_q[3:0]);
        if (blink_q && state_q == SET_MIN) begin
            min_ms_d[6:0] = 7'h7F;
            min_ls_d[6:0] = 7'h7F;
        end
        if (blink_q && state_q == SET_SEC) begin
            sec_ms_d = 7'h7F;
            sec_ls_d = 7'h7F;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            leds_minutes_ms <= 8'hC0;
            leds_minutes_ls <= 8'hC0;
            leds_seconds_ms <= 7'h40;
            leds_seconds_ls <= 7'h40;
            state           <= 2'b00;
        end else begin
            leds_minutes_ms <= min_ms_d;
            leds_minutes_ls <= min_ls_d;
            leds_seconds_ms <= sec_ms_d;
            leds_seconds_ls <= sec_ls_d;
            state           <= state_q;
        end
    end

endmodule
